// File: rtl/hazard_scheduler.sv
// Hazard controller for the 5-stage core: tracks in-flight writers in E/M, derives the
// D-stage stall, per-operand forward selects and the mult/div busy interlock.
module hazard_scheduler #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] d_rs,
  input  logic [4:0] d_rt,
  input  logic [1:0] d_tuse_rs,
  input  logic [1:0] d_tuse_rt,
  input  logic [4:0] d_wa,
  input  logic [1:0] d_tnew,
  input  logic       d_uses_md,
  input  logic [1:0] e_md_op,
  output logic       stall,
  output logic [1:0] fwd_rs_sel,
  output logic [1:0] fwd_rt_sel,
  output logic       md_busy
);

  localparam int MD_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW     = $clog2(MD_MAX + 1);

  typedef enum logic [1:0] {
    FWD_GRF = 2'd0,
    FWD_E   = 2'd1,
    FWD_M   = 2'd2
  } fwd_sel_e;

  localparam logic [1:0] MD_MULT  = 2'b01;
  localparam logic [1:0] MD_DIV   = 2'b10;
  localparam logic [1:0] TUSE_OFF = 2'd3;

  // W is not tracked: its result reaches D through the grf write-through bypass.
  logic [4:0]    e_wa, m_wa;
  logic [1:0]    e_tnew, m_tnew;
  logic [CW-1:0] md_cnt;
  logic          md_issue;

  assign md_issue = (e_md_op == MD_MULT) || (e_md_op == MD_DIV);

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values; blocking here would let m_wa see the new e_wa in the same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      e_wa   <= '0;
      e_tnew <= '0;
      m_wa   <= '0;
      m_tnew <= '0;
      md_cnt <= '0;
    end else begin
      if (stall) begin
        e_wa   <= '0;
        e_tnew <= '0;
      end else begin
        e_wa   <= d_wa;
        e_tnew <= d_tnew;
      end
      m_wa   <= e_wa;
      m_tnew <= (e_tnew == 2'd0) ? 2'd0 : e_tnew - 2'd1;

      if (e_md_op == MD_MULT)     md_cnt <= CW'(MULT_CYCLES);
      else if (e_md_op == MD_DIV) md_cnt <= CW'(DIV_CYCLES);
      else if (md_cnt != '0)      md_cnt <= md_cnt - 1'b1;
    end
  end

  function automatic logic operand_stall(input logic [4:0] r, input logic [1:0] tuse,
                                         input logic [4:0] ewa, input logic [1:0] etn,
                                         input logic [4:0] mwa, input logic [1:0] mtn);
    operand_stall = (r != 5'd0) && (tuse != TUSE_OFF) &&
                    (((ewa == r) && (etn > tuse)) || ((mwa == r) && (mtn > tuse)));
  endfunction

  // E is checked first so the youngest writer wins when both stages hold r.
  function automatic logic [1:0] operand_fwd(input logic [4:0] r,
                                             input logic [4:0] ewa, input logic [1:0] etn,
                                             input logic [4:0] mwa, input logic [1:0] mtn);
    if (r == 5'd0)                        operand_fwd = FWD_GRF;
    else if ((ewa == r) && (etn == 2'd0)) operand_fwd = FWD_E;
    else if ((mwa == r) && (mtn == 2'd0)) operand_fwd = FWD_M;
    else                                  operand_fwd = FWD_GRF;
  endfunction

  // NOTE: every output gets a default first so this block can never infer a latch.
  always_comb begin
    md_busy    = 1'b0;
    stall      = 1'b0;
    fwd_rs_sel = FWD_GRF;
    fwd_rt_sel = FWD_GRF;

    md_busy    = (md_cnt != '0) || md_issue;
    stall      = operand_stall(d_rs, d_tuse_rs, e_wa, e_tnew, m_wa, m_tnew) ||
                 operand_stall(d_rt, d_tuse_rt, e_wa, e_tnew, m_wa, m_tnew) ||
                 (d_uses_md && md_busy);
    fwd_rs_sel = operand_fwd(d_rs, e_wa, e_tnew, m_wa, m_tnew);
    fwd_rt_sel = operand_fwd(d_rt, e_wa, e_tnew, m_wa, m_tnew);
  end

endmodule

// File: tb/tb_hazard_scheduler.sv
// Scoreboard bench for hazard_scheduler: a cycle-indexed model of in-flight writers
// predicts each cycle's outputs; a negedge monitor pops and compares them.
module tb_hazard_scheduler;

  localparam int MULT_CYCLES = 5;
  localparam int DIV_CYCLES  = 10;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] d_rs, d_rt, d_wa;
  logic [1:0] d_tuse_rs, d_tuse_rt, d_tnew, e_md_op;
  logic       d_uses_md;
  logic       stall, md_busy;
  logic [1:0] fwd_rs_sel, fwd_rt_sel;

  hazard_scheduler #(.MULT_CYCLES(MULT_CYCLES), .DIV_CYCLES(DIV_CYCLES)) dut (
    .clk(clk), .reset(reset), .d_rs(d_rs), .d_rt(d_rt),
    .d_tuse_rs(d_tuse_rs), .d_tuse_rt(d_tuse_rt), .d_wa(d_wa), .d_tnew(d_tnew),
    .d_uses_md(d_uses_md), .e_md_op(e_md_op), .stall(stall),
    .fwd_rs_sel(fwd_rs_sel), .fwd_rt_sel(fwd_rt_sel), .md_busy(md_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [4:0] rs, rt, wa;
    logic [1:0] trs, trt, tnew, op;
    logic       umd;
  } stim_t;

  typedef struct {
    int         cyc;
    logic       stall, busy;
    logic [1:0] frs, frt;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  // Model: each instruction is recorded by the cycle it entered E, together with the
  // absolute cycle at which its result becomes available.
  int cyc = 0;
  int ent_wa[int];
  int ent_rdy[int];
  int md_until = -1;

  task automatic check(input string name, input int cy, input int act, input int expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0d expected %0d", name, cy, act, expv);
    end
  endtask

  function automatic void slot(input int c, output int wa, output int rem);
    wa = 0; rem = 0;
    if (ent_wa.exists(c)) begin
      wa  = ent_wa[c];
      rem = (ent_rdy[c] > cyc) ? ent_rdy[c] - cyc : 0;
    end
  endfunction

  function automatic exp_t predict(input stim_t s);
    exp_t e;
    int ewa, erem, mwa, mrem;
    int r[2], tu[2], f[2];
    logic hz;
    slot(cyc, ewa, erem);
    slot(cyc - 1, mwa, mrem);
    r[0] = s.rs; tu[0] = s.trs; r[1] = s.rt; tu[1] = s.trt;
    hz = 1'b0;
    for (int i = 0; i < 2; i++) begin
      if (r[i] != 0 && tu[i] != 3 &&
          ((ewa == r[i] && erem > tu[i]) || (mwa == r[i] && mrem > tu[i]))) hz = 1'b1;
      if (r[i] == 0)                       f[i] = 0;
      else if (ewa == r[i] && erem == 0)   f[i] = 1;
      else if (mwa == r[i] && mrem == 0)   f[i] = 2;
      else                                 f[i] = 0;
    end
    e.cyc   = cyc;
    e.busy  = (s.op == 2'b01) || (s.op == 2'b10) || (cyc <= md_until);
    e.stall = hz || (s.umd && e.busy);
    e.frs   = f[0][1:0];
    e.frt   = f[1][1:0];
    return e;
  endfunction

  // Drive one D/E cycle, push its expectation, then advance the model across the edge.
  task automatic step(input stim_t s);
    exp_t e;
    reset = s.rst; d_rs = s.rs; d_rt = s.rt; d_tuse_rs = s.trs; d_tuse_rt = s.trt;
    d_wa = s.wa; d_tnew = s.tnew; d_uses_md = s.umd; e_md_op = s.op;
    e = predict(s);
    sb.push_back(e);
    @(posedge clk);
    if (s.rst) begin
      ent_wa.delete();
      ent_rdy.delete();
      md_until = -1;
    end else begin
      if (!e.stall) begin
        ent_wa[cyc + 1]  = s.wa;
        ent_rdy[cyc + 1] = cyc + 1 + s.tnew;
      end
      if (s.op == 2'b01) md_until = cyc + MULT_CYCLES;
      if (s.op == 2'b10) md_until = cyc + DIV_CYCLES;
    end
    if (ent_wa.exists(cyc - 2)) begin
      ent_wa.delete(cyc - 2);
      ent_rdy.delete(cyc - 2);
    end
    cyc++;
    #1;
  endtask

  function automatic stim_t idle();
    stim_t s;
    s.rst = 1'b0; s.rs = '0; s.rt = '0; s.wa = '0;
    s.trs = 2'd3; s.trt = 2'd3; s.tnew = '0; s.op = '0; s.umd = 1'b0;
    return s;
  endfunction

  function automatic stim_t wr(input int wa, input int tnew);
    stim_t s = idle();
    s.wa = wa[4:0]; s.tnew = tnew[1:0];
    return s;
  endfunction

  function automatic stim_t rd(input int rs, input int trs, input int rt, input int trt);
    stim_t s = idle();
    s.rs = rs[4:0]; s.trs = trs[1:0]; s.rt = rt[4:0]; s.trt = trt[1:0];
    return s;
  endfunction

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      check("stall",      e.cyc, int'(stall),      int'(e.stall));
      check("md_busy",    e.cyc, int'(md_busy),    int'(e.busy));
      check("fwd_rs_sel", e.cyc, int'(fwd_rs_sel), int'(e.frs));
      check("fwd_rt_sel", e.cyc, int'(fwd_rt_sel), int'(e.frt));
    end
  end

  initial begin
    stim_t s;
    int budget;
    s = idle();
    s.rst = 1'b1;
    reset = 1'b1; d_rs = '0; d_rt = '0; d_tuse_rs = 2'd3; d_tuse_rt = 2'd3;
    d_wa = '0; d_tnew = '0; d_uses_md = 1'b0; e_md_op = '0;
    repeat (2) @(posedge clk);
    #1;
    step(s);                          // reset still asserted: state already cleared
    repeat (2) step(idle());          // post-reset outputs all zero

    // Load-use: lw $8 then a consumer held in D while stalled.
    step(wr(8, 2));
    repeat (3) step(rd(8, 1, 0, 3));
    repeat (2) step(idle());

    // ALU chain: addu $5 then an immediate consumer of $5.
    step(wr(5, 1));
    repeat (3) step(rd(5, 0, 0, 3));
    repeat (2) step(idle());

    // Two writers of $3, then a reader of rt=3; repeat with rt=0.
    step(wr(3, 0)); step(wr(3, 0)); step(rd(0, 3, 3, 1));
    step(wr(3, 0)); step(wr(3, 0)); step(rd(0, 3, 0, 1));
    repeat (2) step(idle());

    // Div issue with mflo waiting in D, held until the interlock clears.
    s = idle(); s.op = 2'b10; s.umd = 1'b1;
    step(s);
    s.op = 2'b00;
    repeat (13) step(s);

    // Mult issue then reissue as div while busy (counter reload).
    s = idle(); s.op = 2'b01; step(s);
    repeat (2) step(idle());
    s.op = 2'b10; step(s);
    s = idle(); s.umd = 1'b1;
    repeat (12) step(s);

    // Reset three cycles after a div issue, with hazards in flight.
    s = idle(); s.op = 2'b10; step(s);
    step(wr(4, 2));
    step(wr(6, 0));
    s = rd(6, 0, 4, 0); s.rst = 1'b1; s.umd = 1'b1;
    step(s);
    s.rst = 1'b0;
    step(s);
    repeat (2) step(idle());

    // Tuse=3 operand must not stall on a late E writer.
    step(wr(7, 2));
    step(rd(7, 3, 0, 3));
    repeat (2) step(idle());

    // Randomized traffic on a small register set to provoke matches.
    for (int i = 0; i < 3000; i++) begin
      s.rst  = ($urandom_range(0, 99) == 0);
      s.rs   = 5'($urandom_range(0, 4));
      s.rt   = 5'($urandom_range(0, 4));
      s.wa   = 5'($urandom_range(0, 4));
      s.trs  = 2'($urandom_range(0, 3));
      s.trt  = 2'($urandom_range(0, 3));
      s.tnew = 2'($urandom_range(0, 3));
      s.umd  = ($urandom_range(0, 3) == 0);
      s.op   = ($urandom_range(0, 19) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      step(s);
    end
    step(idle());

    budget = 20;
    while (sb.size() > 0 && budget > 0) begin
      @(posedge clk);
      budget--;
    end
    if (sb.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
